// File: rtl/cpu_addr_unit.sv
// Address/sequencing datapath: owns PC, SP, IR, call-target temp, I/O port latch
// and halt latch, all stepped by the control FSM's state code each clock.
module cpu_addr_unit #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_cycle,
  input  logic [7:0] state_i,
  input  logic [7:0] mem_rdata_i,
  input  logic [7:0] reg_data_i,
  input  logic       flag_z_i,
  input  logic       flag_c_i,
  output logic [7:0] addr_o,
  output logic       mem_we_o,
  output logic [7:0] mem_wdata_o,
  output logic [7:0] instruction_o,
  output logic [7:0] pc_o,
  output logic [7:0] sp_o,
  output logic [7:0] io_addr_o,
  output logic       halted_o
);

  typedef enum logic [7:0] {
    ST_NEXT       = 8'h00,
    ST_FETCH_PC   = 8'h01,
    ST_FETCH_INST = 8'h02,
    ST_HALT       = 8'h03,
    ST_JUMP       = 8'h04,
    ST_FETCH_SP   = 8'h0C,
    ST_PC_STORE   = 8'h0D,
    ST_TMP_JUMP   = 8'h0E,
    ST_RET        = 8'h0F,
    ST_INC_SP     = 8'h10,
    ST_SET_ADDR   = 8'h11,
    ST_REG_STORE  = 8'h13,
    ST_SET_REG    = 8'h14
  } stateCode_e;

  stateCode_e stateCode;
  logic [7:0] pc_q, pc_d, sp_q, sp_d, addr_q, addr_d;
  logic [7:0] ir_q, ir_d, tmp_q, tmp_d, ioAddr_q, ioAddr_d;
  logic       halted_q, halted_d;
  logic       jumpTaken;
  logic [7:0] pcInc, spInc;

  assign stateCode = stateCode_e'(state_i);
  assign pcInc     = pc_q + 8'd1;
  assign spInc     = sp_q + 8'd1;

  always_comb begin
    jumpTaken = 1'b1;
    case (ir_q[2:0])
      3'b001:  jumpTaken = flag_z_i;
      3'b010:  jumpTaken = ~flag_z_i;
      3'b011:  jumpTaken = flag_c_i;
      3'b100:  jumpTaken = ~flag_c_i;
      default: jumpTaken = 1'b1;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    tmp_d    = tmp_q;
    ioAddr_d = ioAddr_q;
    halted_d = halted_q;
    // Once halted, every register holds until reset.
    if (!halted_q) begin
      case (stateCode)
        ST_NEXT:       ;
        ST_FETCH_PC:   addr_d = pc_q;
        ST_FETCH_INST: begin
          ir_d = mem_rdata_i;
          pc_d = pcInc;
        end
        ST_HALT:       halted_d = 1'b1;
        ST_JUMP:       pc_d = jumpTaken ? mem_rdata_i : pcInc;
        ST_FETCH_SP:   addr_d = sp_q;
        ST_PC_STORE:   sp_d = sp_q - 8'd1;
        ST_TMP_JUMP:   pc_d = tmp_q;
        ST_RET:        pc_d = mem_rdata_i;
        ST_INC_SP: begin
          sp_d   = spInc;
          addr_d = spInc;
        end
        ST_SET_ADDR: begin
          ioAddr_d = mem_rdata_i;
          pc_d     = pcInc;
        end
        ST_REG_STORE:  sp_d = sp_q - 8'd1;
        ST_SET_REG: begin
          // LDI consumes its operand byte; CALL also captures the target; POP does neither.
          if (ir_q[7:3] == 5'b00010) begin
            pc_d = pcInc;
          end else if (ir_q == 8'h01) begin
            tmp_d = mem_rdata_i;
            pc_d  = pcInc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      pc_q     <= PC_RESET;
      sp_q     <= SP_RESET;
      addr_q   <= 8'h00;
      ir_q     <= 8'h00;
      tmp_q    <= 8'h00;
      ioAddr_q <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      tmp_q    <= tmp_d;
      ioAddr_q <= ioAddr_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_wdata_o = 8'h00;
    if (!halted_q) begin
      if (stateCode == ST_PC_STORE) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = pc_q;
      end else if (stateCode == ST_REG_STORE) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = reg_data_i;
      end
    end
  end

  assign addr_o        = addr_q;
  assign instruction_o = ir_q;
  assign pc_o          = pc_q;
  assign sp_o          = sp_q;
  assign io_addr_o     = ioAddr_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_cpu_addr_unit.sv
// Self-checking bench for cpu_addr_unit: directed scenarios plus a random state
// stream checked against a behavioural model with its own 256-byte memory.
module tb_cpu_addr_unit;

  localparam logic [7:0] S_NEXT = 8'h00, S_FETCH_PC = 8'h01, S_FETCH_INST = 8'h02,
                         S_HALT = 8'h03, S_JUMP = 8'h04, S_FETCH_SP = 8'h0C,
                         S_PC_STORE = 8'h0D, S_TMP_JUMP = 8'h0E, S_RET = 8'h0F,
                         S_INC_SP = 8'h10, S_SET_ADDR = 8'h11, S_REG_STORE = 8'h13,
                         S_SET_REG = 8'h14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetCycle;
  logic [7:0] stateIn, memRdata, regData;
  logic       flagZ, flagC;
  logic [7:0] addrOut, memWdata, instrOut, pcOut, spOut, ioAddrOut;
  logic       memWe, haltedOut;

  logic [7:0] mem [256];
  assign memRdata = mem[addrOut];

  int errors = 0;
  int checks = 0;

  logic [7:0] mPc, mSp, mAddr, mIr, mTmp, mIo;
  logic       mHalt;
  logic [7:0] nPc, nSp, nAddr, nIr, nTmp, nIo;
  logic       nHalt, expWe;
  logic [7:0] expWdata;

  logic [7:0] codes [13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C, 8'h0D,
                             8'h0E, 8'h0F, 8'h10, 8'h11, 8'h13, 8'h14};

  cpu_addr_unit dut (
    .clk(clk), .reset_cycle(resetCycle), .state_i(stateIn), .mem_rdata_i(memRdata),
    .reg_data_i(regData), .flag_z_i(flagZ), .flag_c_i(flagC), .addr_o(addrOut),
    .mem_we_o(memWe), .mem_wdata_o(memWdata), .instruction_o(instrOut), .pc_o(pcOut),
    .sp_o(spOut), .io_addr_o(ioAddrOut), .halted_o(haltedOut)
  );

  task automatic modelReset();
    mPc = 8'h00; mSp = 8'hFF; mAddr = 8'h00; mIr = 8'h00; mTmp = 8'h00; mIo = 8'h00; mHalt = 1'b0;
  endtask

  // Behavioural next-state: what each state code means, computed on the model's own memory.
  task automatic modelNext(input logic [7:0] st);
    logic [7:0] rd;
    logic take;
    rd = mem[mAddr];
    nPc = mPc; nSp = mSp; nAddr = mAddr; nIr = mIr; nTmp = mTmp; nIo = mIo; nHalt = mHalt;
    expWe = 1'b0; expWdata = 8'h00;
    if (!mHalt) begin
      case (st)
        S_FETCH_PC:   nAddr = mPc;
        S_FETCH_INST: begin nIr = rd; nPc = mPc + 8'd1; end
        S_HALT:       nHalt = 1'b1;
        S_JUMP: begin
          if (mIr[2:0] == 3'd1) take = flagZ;
          else if (mIr[2:0] == 3'd2) take = !flagZ;
          else if (mIr[2:0] == 3'd3) take = flagC;
          else if (mIr[2:0] == 3'd4) take = !flagC;
          else take = 1'b1;
          nPc = take ? rd : mPc + 8'd1;
        end
        S_FETCH_SP:   nAddr = mSp;
        S_PC_STORE:   begin expWe = 1'b1; expWdata = mPc; nSp = mSp - 8'd1; end
        S_REG_STORE:  begin expWe = 1'b1; expWdata = regData; nSp = mSp - 8'd1; end
        S_TMP_JUMP:   nPc = mTmp;
        S_RET:        nPc = rd;
        S_INC_SP:     begin nSp = mSp + 8'd1; nAddr = mSp + 8'd1; end
        S_SET_ADDR:   begin nIo = rd; nPc = mPc + 8'd1; end
        S_SET_REG: begin
          if (mIr >= 8'h10 && mIr <= 8'h17) nPc = mPc + 8'd1;
          else if (mIr == 8'h01) begin nTmp = rd; nPc = mPc + 8'd1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    resetCycle = 1'b1; stateIn = S_NEXT;
    #2;
    resetCycle = 1'b0;
    modelReset();
  endtask

  task automatic drive(input logic [7:0] st);
    stateIn = st;
    #1;
    modelNext(st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (expWe) mem[mAddr] = expWdata;
    mPc = nPc; mSp = nSp; mAddr = nAddr; mIr = nIr; mTmp = nTmp; mIo = nIo; mHalt = nHalt;
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] st);
    drive(st);
    tick();
  endtask

  task automatic jumpFromReset(input logic [7:0] target);
    doReset();
    flagZ = 1'b0; flagC = 1'b0;
    mem[0] = 8'h18; mem[1] = target;
    step(S_FETCH_PC); step(S_FETCH_INST); step(S_FETCH_PC); step(S_JUMP);
  endtask

  task automatic test_reset();
    resetCycle = 1'b1;
    #3;
    checks++; if (pcOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=00", pcOut); end
    checks++; if (spOut !== 8'hFF) begin errors++; $display("[TB] FAIL reset_sp got=%h exp=FF", spOut); end
    checks++; if (addrOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=00", addrOut); end
    checks++; if (instrOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_ir got=%h exp=00", instrOut); end
    checks++; if (ioAddrOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_io got=%h exp=00", ioAddrOut); end
    checks++; if (haltedOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got=%b exp=0", haltedOut); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b exp=0", memWe); end
    resetCycle = 1'b0;
    modelReset();
  endtask

  task automatic test_fetch();
    doReset();
    mem[0] = 8'h10;
    step(S_FETCH_PC);
    checks++; if (addrOut !== 8'h00) begin errors++; $display("[TB] FAIL fetch_addr0 got=%h exp=00", addrOut); end
    step(S_FETCH_INST);
    checks++; if (instrOut !== 8'h10) begin errors++; $display("[TB] FAIL fetch_ir got=%h exp=10", instrOut); end
    step(S_FETCH_PC);
    checks++; if (addrOut !== 8'h01) begin errors++; $display("[TB] FAIL fetch_addr1 got=%h exp=01", addrOut); end
    step(S_SET_REG);
    checks++; if (pcOut !== 8'h02) begin errors++; $display("[TB] FAIL fetch_ldi_pc got=%h exp=02", pcOut); end
  endtask

  task automatic test_jump();
    doReset();
    mem[0] = 8'h19; mem[1] = 8'h40;
    step(S_FETCH_PC); step(S_FETCH_INST); step(S_FETCH_PC);
    flagZ = 1'b1;
    step(S_JUMP);
    checks++; if (pcOut !== 8'h40) begin errors++; $display("[TB] FAIL jz_taken_pc got=%h exp=40", pcOut); end
    jumpFromReset(8'h04);
    mem[4] = 8'h19; mem[5] = 8'h40;
    step(S_FETCH_PC); step(S_FETCH_INST); step(S_FETCH_PC);
    flagZ = 1'b0;
    step(S_JUMP);
    checks++; if (pcOut !== 8'h06) begin errors++; $display("[TB] FAIL jz_not_taken_pc got=%h exp=06", pcOut); end
    jumpFromReset(8'hFF);
    checks++; if (pcOut !== 8'hFF) begin errors++; $display("[TB] FAIL jmp_ff_pc got=%h exp=FF", pcOut); end
    step(S_FETCH_PC); step(S_FETCH_INST);
    checks++; if (pcOut !== 8'h00) begin errors++; $display("[TB] FAIL pc_wrap got=%h exp=00", pcOut); end
  endtask

  task automatic test_call_ret();
    jumpFromReset(8'h0F);
    mem[8'h0F] = 8'h01; mem[8'h10] = 8'h80;
    step(S_FETCH_PC); step(S_FETCH_INST); step(S_FETCH_PC); step(S_SET_REG);
    checks++; if (pcOut !== 8'h11) begin errors++; $display("[TB] FAIL call_pc got=%h exp=11", pcOut); end
    step(S_FETCH_SP);
    drive(S_PC_STORE);
    checks++; if (memWe !== 1'b1 || memWdata !== 8'h11 || addrOut !== 8'hFF) begin
      errors++; $display("[TB] FAIL call_push got we=%b data=%h addr=%h exp we=1 data=11 addr=FF", memWe, memWdata, addrOut);
    end
    tick();
    checks++; if (spOut !== 8'hFE) begin errors++; $display("[TB] FAIL call_sp got=%h exp=FE", spOut); end
    step(S_TMP_JUMP);
    checks++; if (pcOut !== 8'h80) begin errors++; $display("[TB] FAIL call_target got=%h exp=80", pcOut); end
    step(S_INC_SP);
    checks++; if (spOut !== 8'hFF || addrOut !== 8'hFF) begin
      errors++; $display("[TB] FAIL ret_inc_sp got sp=%h addr=%h exp FF FF", spOut, addrOut);
    end
    step(S_FETCH_SP); step(S_RET);
    checks++; if (pcOut !== 8'h11) begin errors++; $display("[TB] FAIL ret_pc got=%h exp=11", pcOut); end
  endtask

  task automatic test_push_wrap();
    doReset();
    step(S_INC_SP);
    checks++; if (spOut !== 8'h00) begin errors++; $display("[TB] FAIL sp_inc_wrap got=%h exp=00", spOut); end
    step(S_FETCH_SP);
    regData = 8'hAB;
    drive(S_REG_STORE);
    checks++; if (memWe !== 1'b1 || memWdata !== 8'hAB || addrOut !== 8'h00) begin
      errors++; $display("[TB] FAIL push_write got we=%b data=%h addr=%h exp we=1 data=AB addr=00", memWe, memWdata, addrOut);
    end
    tick();
    checks++; if (spOut !== 8'hFF) begin errors++; $display("[TB] FAIL sp_dec_wrap got=%h exp=FF", spOut); end
  endtask

  task automatic test_io_default();
    jumpFromReset(8'h1F);
    mem[8'h1F] = 8'h03; mem[8'h20] = 8'h07;
    step(S_FETCH_PC); step(S_FETCH_INST); step(S_FETCH_PC); step(S_SET_ADDR);
    checks++; if (ioAddrOut !== 8'h07 || pcOut !== 8'h21) begin
      errors++; $display("[TB] FAIL io_set got io=%h pc=%h exp 07 21", ioAddrOut, pcOut);
    end
    drive(8'h3F);
    checks++; if (memWe !== 1'b0 || memWdata !== 8'h00) begin
      errors++; $display("[TB] FAIL default_we got we=%b data=%h exp 0 00", memWe, memWdata);
    end
    tick();
    checks++; if (pcOut !== 8'h21 || ioAddrOut !== 8'h07 || spOut !== 8'hFF || addrOut !== 8'h20 || instrOut !== 8'h03) begin
      errors++; $display("[TB] FAIL default_hold got pc=%h io=%h sp=%h addr=%h ir=%h exp 21 07 FF 20 03",
                        pcOut, ioAddrOut, spOut, addrOut, instrOut);
    end
  endtask

  task automatic test_halt();
    doReset();
    mem[0] = 8'h2A;
    step(S_FETCH_PC); step(S_FETCH_INST);
    mem[0] = 8'h55; mem[1] = 8'h77;
    step(S_HALT);
    checks++; if (haltedOut !== 1'b1) begin errors++; $display("[TB] FAIL halt_set got=%b exp=1", haltedOut); end
    step(S_FETCH_INST); step(S_FETCH_PC); step(S_JUMP);
    checks++; if (pcOut !== 8'h01 || instrOut !== 8'h2A) begin
      errors++; $display("[TB] FAIL halt_freeze got pc=%h ir=%h exp 01 2A", pcOut, instrOut);
    end
    drive(S_PC_STORE);
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL halt_we got=%b exp=0", memWe); end
    tick();
    checks++; if (spOut !== 8'hFF || haltedOut !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_sp got sp=%h halted=%b exp FF 1", spOut, haltedOut);
    end
    #2;
    resetCycle = 1'b1;
    #1;
    checks++; if (haltedOut !== 1'b0 || pcOut !== 8'h00 || spOut !== 8'hFF) begin
      errors++; $display("[TB] FAIL async_reset got halted=%b pc=%h sp=%h exp 0 00 FF", haltedOut, pcOut, spOut);
    end
    resetCycle = 1'b0;
    modelReset();
  endtask

  task automatic test_random();
    logic [7:0] st;
    doReset();
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    mem[i] = 8'h10 | 8'($urandom_range(0, 7));
        2:       mem[i] = 8'h01;
        default: mem[i] = 8'($urandom);
      endcase
    end
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 7) == 0) ? 8'($urandom) : codes[$urandom_range(0, 12)];
      if (st == S_HALT) st = S_NEXT;
      flagZ = 1'($urandom); flagC = 1'($urandom); regData = 8'($urandom);
      drive(st);
      checks++; if (memWe !== expWe || memWdata !== expWdata) begin
        errors++; $display("[TB] FAIL rnd_write st=%h got we=%b data=%h exp we=%b data=%h", st, memWe, memWdata, expWe, expWdata);
      end
      tick();
      checks++; if (pcOut !== mPc || spOut !== mSp || addrOut !== mAddr) begin
        errors++; $display("[TB] FAIL rnd_ptrs st=%h got pc=%h sp=%h addr=%h exp pc=%h sp=%h addr=%h",
                          st, pcOut, spOut, addrOut, mPc, mSp, mAddr);
      end
      checks++; if (instrOut !== mIr || ioAddrOut !== mIo || haltedOut !== mHalt) begin
        errors++; $display("[TB] FAIL rnd_regs st=%h got ir=%h io=%h halted=%b exp ir=%h io=%h halted=%b",
                          st, instrOut, ioAddrOut, haltedOut, mIr, mIo, mHalt);
      end
    end
  endtask

  initial begin
    resetCycle = 1'b0; stateIn = S_NEXT; regData = 8'h00; flagZ = 1'b0; flagC = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    modelReset();
    test_reset();
    test_fetch();
    test_jump();
    test_call_ret();
    test_push_wrap();
    test_io_default();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_addr_unit.md
Name: cpu_addr_unit

Overview:
- Address/sequencing datapath that consumes the 8-bit `state` code from the CPU control FSM each clock.
- Owns the program counter (PC), stack pointer (SP), instruction register (IR), call-target temp (TMP), I/O address latch and halt latch.
- Drives the memory address and write strobe, and feeds IR back to the control FSM's `instruction` input.
- Sits between the control FSM and the unified 256-byte memory.

Parameters:
- PC_RESET, 8'h00, PC value after reset
- SP_RESET, 8'hFF, SP value after reset (stack grows downward)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_cycle  in  1  reset, asynchronous, active-high
- state  in  8  control FSM state code (encoding listed under Behaviour)
- mem_rdata  in  8  memory read data, valid for the word at `addr`
- reg_data  in  8  register-file read data, used for PUSH
- flag_z  in  1  ALU zero flag
- flag_c  in  1  ALU carry flag
- addr  out  8  registered memory address
- mem_we  out  1  memory write strobe, combinational from `state`
- mem_wdata  out  8  memory write data, combinational
- instruction  out  8  IR contents
- pc  out  8  program counter
- sp  out  8  stack pointer
- io_addr  out  8  latched port number for IN/OUT
- halted  out  1  sticky halt flag

Behaviour:
- Reset is asynchronous, active-high on `reset_cycle`. While asserted: pc=PC_RESET, sp=SP_RESET, addr=0, instruction=0 (NOP), io_addr=0, TMP=0, halted=0.
- State codes: NEXT 00, FETCH_PC 01, FETCH_INST 02, HALT 03, JUMP 04, FETCH_SP 0C, PC_STORE 0D, TMP_JUMP 0E, RET 0F, INC_SP 10, SET_ADDR 11, REG_STORE 13, SET_REG 14.
- Any other code: no register change, mem_we=0.
- Per-state actions, applied at the clock edge where `state` holds that code:
  - FETCH_PC: addr<=pc.
  - FETCH_INST: instruction<=mem_rdata; pc<=pc+1.
  - HALT: halted<=1.
  - FETCH_SP: addr<=sp.
  - INC_SP: sp<=sp+1, then addr<=sp+1 (new value) so that RET/POP read the top-of-stack.
  - PC_STORE: mem_we=1; mem_wdata=pc; sp<=sp-1.
  - REG_STORE: mem_we=1; mem_wdata=reg_data; sp<=sp-1.
  - SET_REG:
    - IR[7:3]=00_010 (LDI): pc<=pc+1.
    - IR=00_000_001 (CALL): TMP<=mem_rdata; pc<=pc+1.
    - Otherwise (POP): no pc change.
  - SET_ADDR: io_addr<=mem_rdata; pc<=pc+1.
  - JUMP: condition taken from IR[2:0].
    - 000 always; 001 Z; 010 !Z; 011 C; 100 !C; 101–111 always.
    - Taken: pc<=mem_rdata. Not taken: pc<=pc+1 (skip operand byte).
  - TMP_JUMP: pc<=TMP.
  - RET: pc<=mem_rdata.
  - NEXT: no change.
- mem_we is 0 in every state other than PC_STORE and REG_STORE. mem_wdata=0 when mem_we=0.
- All pc/sp arithmetic is modulo 256: pc FF+1 -> 00; sp 00-1 -> FF; sp FF+1 -> 00. No overflow flag.
- Halt:
  - Once halted=1, all registers freeze regardless of `state`, and mem_we is forced to 0.
  - Only reset clears halted.
- Reset asserted mid-instruction (e.g. between PC_STORE and TMP_JUMP) returns all registers to reset values immediately. The partial stack write is not undone.
- Latency: every update is visible one clock after the edge on which `state` was sampled. mem_we/mem_wdata are valid in the same cycle as `state`.

Test Plan:
- Fetch: reset, pc=00, mem[00]=0x10 (LDI), state sequence FETCH_PC, FETCH_INST, FETCH_PC, SET_REG -> addr=00 then 01, instruction=0x10, pc=02 at end.
- Jump: IR=0x19 (JMP Z), mem_rdata=0x40, JUMP with flag_z=1 -> pc=40. Repeat with flag_z=0 from pc=05 -> pc=06.
- Call/return:
  - CALL at pc=10 with target 0x80, sp=FF: SET_REG, FETCH_SP, PC_STORE, TMP_JUMP -> write of 0x11 at addr FF, sp=FE, pc=80.
  - Then INC_SP, FETCH_SP, RET with mem_rdata=0x11 -> sp=FF, pc=11.
- Push wrap: sp=00, reg_data=0xAB, FETCH_SP then REG_STORE -> mem_we=1 at addr 00, data AB, sp=FF.
- Halt: HALT state -> halted=1. Subsequent FETCH_INST/JUMP leave pc/instruction unchanged, mem_we=0 during PC_STORE. Assert reset_cycle asynchronously (no clk edge) -> halted=0, pc=00, sp=FF.
- IO/default: IR=0x03 (OUT), SET_ADDR with mem_rdata=0x07 at pc=20 -> io_addr=07, pc=21. Drive state=0x3F -> no register change, mem_we=0.
